// File: rtl/conv3x3_edge_filter.sv
// Streaming 3x3 Sobel / pass-through filter: two line buffers, 3x3 window, 3-stage pipeline.
// Define CONV_THRESH_EN to binarize modes 01-11 against THRESH.
module conv3x3_edge_filter #(
  parameter int unsigned LINE_W = 640,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned THRESH = 512
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [15:0]       iX_Cont,
  input  logic [15:0]       iY_Cont,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [15:0]       oX_Cont,
  output logic [15:0]       oY_Cont
);
  localparam int unsigned AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned GW = DATA_W + 3;
  localparam logic [GW-1:0] SatMax = GW'((1 << DATA_W) - 1);
`ifdef CONV_THRESH_EN
  localparam logic [GW-1:0] ThreshVal = GW'(THRESH);
`endif

  logic [DATA_W-1:0] lb0_mem [LINE_W];
  logic [DATA_W-1:0] lb1_mem [LINE_W];
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  assign addr   = iX_Cont[AW-1:0];
  assign lb0_rd = lb0_mem[addr];
  assign lb1_rd = lb1_mem[addr];

  // Read-before-write: the values read this cycle are the ones shifted down a row.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lb1_mem[addr] <= lb0_rd;
      lb0_mem[addr] <= iDATA;
    end
  end

  logic [1:0] mode_q, mode_px;
  logic       frame_start, border_px;

  assign frame_start = (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
  assign mode_px     = frame_start ? iMODE : mode_q;
  assign border_px   = (iX_Cont < 16'd2) || (iY_Cont < 16'd2) || (iX_Cont >= 16'(LINE_W));

  // Window is [row][col]; row 2 is the current line, col 2 the newest column.
  logic [DATA_W-1:0] win_q [3][3];
  logic              s1_vld_q, s1_border_q;
  logic [15:0]       s1_x_q, s1_y_q;
  logic [1:0]        s1_mode_q;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      mode_q      <= 2'b00;
      s1_vld_q    <= 1'b0;
      s1_border_q <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_mode_q   <= 2'b00;
    end else begin
      s1_vld_q <= iDVAL;
      if (iDVAL) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_rd;
        win_q[1][2] <= lb0_rd;
        win_q[2][2] <= iDATA;
        s1_x_q      <= iX_Cont - 16'd1;
        s1_y_q      <= iY_Cont - 16'd1;
        s1_mode_q   <= mode_px;
        s1_border_q <= border_px;
        if (frame_start) mode_q <= iMODE;
      end
    end
  end

  logic signed [GW-1:0] px [3][3];
  logic signed [GW-1:0] gx, gy;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px[r][c] = $signed(GW'(win_q[r][c]));
      end
    end
    gx = (px[0][2] + px[1][2] + px[1][2] + px[2][2]) - (px[0][0] + px[1][0] + px[1][0] + px[2][0]);
    gy = (px[2][0] + px[2][1] + px[2][1] + px[2][2]) - (px[0][0] + px[0][1] + px[0][1] + px[0][2]);
  end

  logic signed [GW-1:0] s2_gx_q, s2_gy_q;
  logic [DATA_W-1:0]    s2_ctr_q;
  logic                 s2_vld_q, s2_border_q;
  logic [15:0]          s2_x_q, s2_y_q;
  logic [1:0]           s2_mode_q;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s2_gx_q     <= '0;
      s2_gy_q     <= '0;
      s2_ctr_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_border_q <= 1'b0;
      s2_x_q      <= '0;
      s2_y_q      <= '0;
      s2_mode_q   <= 2'b00;
    end else begin
      s2_gx_q     <= gx;
      s2_gy_q     <= gy;
      s2_ctr_q    <= win_q[1][1];
      s2_vld_q    <= s1_vld_q;
      s2_border_q <= s1_border_q;
      s2_x_q      <= s1_x_q;
      s2_y_q      <= s1_y_q;
      s2_mode_q   <= s1_mode_q;
    end
  end

  logic [GW-1:0]     abs_x, abs_y, mag;
  logic [DATA_W-1:0] edge_val, result;

  always_comb begin
    abs_x = s2_gx_q[GW-1] ? unsigned'(-s2_gx_q) : unsigned'(s2_gx_q);
    abs_y = s2_gy_q[GW-1] ? unsigned'(-s2_gy_q) : unsigned'(s2_gy_q);
    case (s2_mode_q)
      2'b01:   mag = abs_x;
      2'b10:   mag = abs_y;
      default: mag = abs_x + abs_y;
    endcase
`ifdef CONV_THRESH_EN
    edge_val = (((mag > SatMax) ? SatMax : mag) >= ThreshVal) ? {DATA_W{1'b1}} : '0;
`else
    edge_val = (mag > SatMax) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
`endif
    result = (s2_mode_q == 2'b00) ? s2_ctr_q : (s2_border_q ? '0 : edge_val);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL   <= 1'b0;
      oDATA   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDVAL   <= s2_vld_q;
      oDATA   <= result;
      oX_Cont <= s2_x_q;
      oY_Cont <= s2_y_q;
    end
  end
endmodule
